// File: rtl/my_boot_loader.sv
// Boot loader: receives a length-prefixed 16-bit word image over a byte link, writes it into
// instruction RAM and holds the CPU in reset until the load succeeds. Option: BOOT_CHECKSUM_EN.
module my_boot_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 32768,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_wr_en,
  output logic [ADDR_W-1:0] rom_wr_addr,
  output logic [15:0]       rom_wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [3:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StChkHi, StChkLo, StRun, StError
  } state_e;

`ifdef BOOT_CHECKSUM_EN
  localparam state_e StFinal = StChkHi;
`else
  localparam state_e StFinal = StRun;
`endif

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e              r_state, w_state;
  logic [15:0]         r_len, w_len;
  logic [7:0]          r_hi, w_hi;
  logic [7:0]          r_lo, w_lo;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [15:0]         r_words, w_words;
  logic [15:0]         r_sum, w_sum;
  logic [7:0]          r_chk_hi, w_chk_hi;
  logic [31:0]         r_idle, w_idle;
  logic                w_accept;
  logic                w_wait;
  logic [15:0]         w_len_full;

  assign w_accept   = in_valid && in_ready;
  assign w_len_full = {r_len[15:8], in_data};
  // LEN_HI is a byte-wait state but is exempt from the idle timeout.
  assign w_wait     = (r_state == StLenLo) || (r_state == StDataHi) || (r_state == StDataLo) ||
                      (r_state == StChkHi) || (r_state == StChkLo);

  always_comb begin
    w_state  = r_state;
    w_len    = r_len;
    w_hi     = r_hi;
    w_lo     = r_lo;
    w_addr   = r_addr;
    w_words  = r_words;
    w_sum    = r_sum;
    w_chk_hi = r_chk_hi;
    w_idle   = r_idle;
    if (w_accept) w_idle = '0;
    else if (w_wait) w_idle = r_idle + 32'd1;

    case (r_state)
      StIdle, StRun, StError: begin
        if (start) begin
          w_state = StLenHi;
          w_words = '0;
          w_addr  = '0;
          w_sum   = '0;
          w_idle  = '0;
        end
      end
      StLenHi: begin
        w_idle = '0;
        if (w_accept) begin
          w_len[15:8] = in_data;
          w_state     = StLenLo;
        end
      end
      StLenLo: begin
        if (w_accept) begin
          w_len = w_len_full;
          if (w_len_full == 16'd0) w_state = StFinal;
          else if (32'(w_len_full) > MAX_WORDS) w_state = StError;
          else w_state = StDataHi;
        end
      end
      StDataHi: begin
        if (w_accept) begin
          w_hi    = in_data;
          w_state = StDataLo;
        end
      end
      StDataLo: begin
        if (w_accept) begin
          w_lo    = in_data;
          w_state = StWrite;
        end
      end
      StWrite: begin
        w_addr  = r_addr + AddrOne;
        w_words = r_words + 16'd1;
        w_sum   = r_sum + {r_hi, r_lo};
        w_state = (w_words == r_len) ? StFinal : StDataHi;
      end
      StChkHi: begin
        if (w_accept) begin
          w_chk_hi = in_data;
          w_state  = StChkLo;
        end
      end
      StChkLo: begin
        if (w_accept) w_state = ({r_chk_hi, in_data} == r_sum) ? StRun : StError;
      end
      default: w_state = StIdle;
    endcase

    if (TIMEOUT != 0 && w_wait && !w_accept && w_idle >= TIMEOUT) w_state = StError;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_len    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_addr   <= '0;
      r_words  <= '0;
      r_sum    <= '0;
      r_chk_hi <= '0;
      r_idle   <= '0;
    end else begin
      r_state  <= w_state;
      r_len    <= w_len;
      r_hi     <= w_hi;
      r_lo     <= w_lo;
      r_addr   <= w_addr;
      r_words  <= w_words;
      r_sum    <= w_sum;
      r_chk_hi <= w_chk_hi;
      r_idle   <= w_idle;
    end
  end

  always_comb begin
    in_ready = (r_state == StLenHi) || (r_state == StLenLo) || (r_state == StDataHi) ||
               (r_state == StDataLo) || (r_state == StChkHi) || (r_state == StChkLo);
    rom_wr_en    = (r_state == StWrite);
    rom_wr_addr  = r_addr;
    rom_wr_data  = {r_hi, r_lo};
    busy         = !((r_state == StIdle) || (r_state == StRun) || (r_state == StError));
    done         = (r_state == StRun);
    error        = (r_state == StError);
    cpu_reset    = (r_state != StRun);
    words_loaded = r_words;
  end

endmodule

// File: tb/tb_my_boot_loader.sv
// Self-checking bench for my_boot_loader: table vectors, hand sequences for corner cases and
// randomized images scored against an image-level model. Honours BOOT_CHECKSUM_EN.
module tb_my_boot_loader;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned MAX_WORDS = 32768;
  localparam int unsigned TIMEOUT   = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, rom_wr_en, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0] rom_wr_addr;
  logic [15:0]       rom_wr_data, words_loaded;

  my_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rom_wr_en(rom_wr_en), .rom_wr_addr(rom_wr_addr),
    .rom_wr_data(rom_wr_data), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          wr_total = 0;
  logic [30:0] got_q[$];
  logic [30:0] exp_q[$];
  logic [15:0] img[$];

  typedef struct {
    logic [15:0] n;
    logic [15:0] w0, w1, w2;
    bit          exp_err;
    logic [15:0] exp_wl;
  } vec_t;
  vec_t vt[6];

  always @(negedge clk) begin
    if (rom_wr_en === 1'b1) begin
      got_q.push_back({rom_wr_addr, rom_wr_data});
      wr_total++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("accept_wait", 32'(in_ready), 32'd1);
    else @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy === 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) chk({name, "_idle_wait"}, 32'(busy), 32'd0);
  endtask

  // Sends the image in img[] (length n); expected writes come straight from the image.
  task automatic load(input string name, input logic [15:0] n, input int max_gap,
                      input bit mid_start, input bit bad_sum);
    logic [15:0] sum = 16'd0;
    pulse_start();
    got_q.delete();
    exp_q.delete();
    send_byte(n[15:8], $urandom_range(max_gap, 0));
    send_byte(n[7:0], $urandom_range(max_gap, 0));
    if (32'(n) <= MAX_WORDS) begin
      for (int i = 0; i < int'(n); i++) begin
        send_byte(img[i][15:8], $urandom_range(max_gap, 0));
        send_byte(img[i][7:0], $urandom_range(max_gap, 0));
        exp_q.push_back({i[14:0], img[i]});
        sum = sum + img[i];
        if (i == 0 && mid_start) begin
          drop_valid();
          pulse_start();
        end
      end
`ifdef BOOT_CHECKSUM_EN
      if (bad_sum) sum = sum + 16'd1;
      send_byte(sum[15:8], $urandom_range(max_gap, 0));
      send_byte(sum[7:0], $urandom_range(max_gap, 0));
`endif
    end
    drop_valid();
    wait_idle(name);
  endtask

  task automatic check_result(input string name, input bit exp_err, input logic [15:0] exp_wl);
    chk({name, "_done"}, 32'(done), 32'(!exp_err));
    chk({name, "_error"}, 32'(error), 32'(exp_err));
    chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    chk({name, "_words"}, 32'(words_loaded), 32'(exp_wl));
    chk({name, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_wr%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit ms;
    bit bad;
    vt[0] = '{16'd0,     16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0};
    vt[1] = '{16'd1,     16'hBEEF, 16'h0000, 16'h0000, 1'b0, 16'd1};
    vt[2] = '{16'd3,     16'h0000, 16'hFFFF, 16'h8001, 1'b0, 16'd3};
    vt[3] = '{16'd32769, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'd0};
    vt[4] = '{16'd65535, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'd0};
    vt[5] = '{16'd2,     16'h7FFF, 16'h0100, 16'h0000, 1'b0, 16'd2};

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_no_write", 32'(wr_total), 32'd0);

    // Back-to-back two-word image.
    img = '{16'h1234, 16'hABCD};
    load("basic", 16'd2, 0, 1'b0, 1'b0);
    check_result("basic", 1'b0, 16'd2);

    // Restart from RUN re-holds the CPU; then oversize length.
    pulse_start();
    chk("rerun_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rerun_busy", 32'(busy), 32'd1);
    base = wr_total;
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    drop_valid();
    chk("big_error", 32'(error), 32'd1);
    chk("big_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("big_busy", 32'(busy), 32'd0);
    chk("big_no_write", 32'(wr_total - base), 32'd0);
    pulse_start();
    chk("err_clear", 32'(error), 32'd0);
    chk("err_restart_busy", 32'(busy), 32'd1);

    // Idle timeout in DATA_LO.
    base = wr_total;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    drop_valid();
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("to_before", 32'(error), 32'd0);
    @(negedge clk);
    chk("to_after", 32'(error), 32'd1);
    chk("to_no_write", 32'(wr_total - base), 32'd0);
    chk("to_cpu_reset", 32'(cpu_reset), 32'd1);

    // Reset after the first of three words, then a clean reload from address 0.
    img = '{16'h1111, 16'h2222, 16'h3333};
    pulse_start();
    got_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    drop_valid();
    @(negedge clk);
    chk("mid_one_write", 32'(got_q.size()), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_words", 32'(words_loaded), 32'd0);
    @(negedge clk) reset = 1'b0;
    load("reload", 16'd3, 1, 1'b0, 1'b0);
    check_result("reload", 1'b0, 16'd3);

    // start while busy must not disturb the load.
    img = '{16'hCAFE, 16'h0BAD, 16'hF00D};
    load("busy_start", 16'd3, 0, 1'b1, 1'b0);
    check_result("busy_start", 1'b0, 16'd3);

    for (int v = 0; v < 6; v++) begin
      img = '{vt[v].w0, vt[v].w1, vt[v].w2};
      load($sformatf("vec%0d", v), vt[v].n, 2, 1'b0, 1'b0);
      check_result($sformatf("vec%0d", v), vt[v].exp_err, vt[v].exp_wl);
    end

`ifdef BOOT_CHECKSUM_EN
    img = '{16'h0001, 16'h0002};
    load("sum_ok", 16'd2, 0, 1'b0, 1'b0);
    check_result("sum_ok", 1'b0, 16'd2);
    load("sum_bad", 16'd2, 0, 1'b0, 1'b1);
    check_result("sum_bad", 1'b1, 16'd2);
`endif

    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(10, 1);
      ms = ($urandom_range(3, 0) == 0);
      bad = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      bad = ($urandom_range(3, 0) == 0);
`endif
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom()));
      load($sformatf("rnd%0d", r), 16'(n), 3, ms, bad);
      check_result($sformatf("rnd%0d", r), bad, 16'(n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
